// File: rtl/sa_read_channel.sv
// Read-channel slave adapter: round-robin AR arbitration across dispatchers,
// with in-order R burst routing driven by an ordering FIFO of granted indices.
module sa_read_channel #(
  parameter int unsigned MST_AMT           = 2,
  parameter int unsigned OUTSTANDING_AMT   = 8,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_MST_ID_W    = 5,
  parameter int unsigned TRANS_BURST_W     = 2,
  parameter int unsigned TRANS_DATA_LEN_W  = 3,
  parameter int unsigned TRANS_DATA_SIZE_W = 3,
  parameter int unsigned TRANS_WR_RESP_W   = 2,
  localparam int unsigned MST_ID_W         = $clog2(MST_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
  input  logic [MST_AMT-1:0]                    dsp_AR_outst_full_i,
  output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
  input  logic [MST_AMT-1:0]                    dsp_RREADY_i,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]         dsp_RDATA_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]    dsp_RRESP_o,
  output logic [MST_AMT-1:0]                    dsp_RLAST_o,
  output logic [MST_AMT-1:0]                    dsp_RVALID_o,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o
);

  localparam int unsigned PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_AMT) + 1;

  logic [MST_AMT-1:0]           eligible;
  logic [MST_ID_W-1:0]          rr_ptr;
  logic [MST_ID_W-1:0]          grant_idx;
  logic                         grant_vld;
  logic                         grant;
  logic                         ar_free;
  logic [TRANS_MST_ID_W-1:0]    sel_id;
  logic [ADDR_WIDTH-1:0]        sel_addr;
  logic [TRANS_BURST_W-1:0]     sel_burst;
  logic [TRANS_DATA_LEN_W-1:0]  sel_len;
  logic [TRANS_DATA_SIZE_W-1:0] sel_size;

  logic [MST_ID_W-1:0]          fifo_mem [OUTSTANDING_AMT];
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic [MST_ID_W-1:0]          head;
  logic                         pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign eligible   = dsp_ARVALID_i & ~dsp_AR_outst_full_i;
  assign ar_free    = ~s_ARVALID_o | s_ARREADY_i;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(OUTSTANDING_AMT));
  assign grant      = grant_vld & ar_free & ~fifo_full;
  assign head       = fifo_mem[rd_ptr];

  // Round-robin search: first eligible index at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < MST_AMT; k++) begin
      cand = (32'(rr_ptr) + k) % MST_AMT;
      if (!grant_vld && eligible[MST_ID_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = MST_ID_W'(cand);
      end
    end
  end

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_burst = '0;
    sel_len   = '0;
    sel_size  = '0;
    for (int unsigned i = 0; i < MST_AMT; i++) begin
      if (grant_idx == MST_ID_W'(i)) begin
        sel_id    = dsp_ARID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr  = dsp_ARADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_burst = dsp_ARBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
        sel_len   = dsp_ARLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        sel_size  = dsp_ARSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  assign dsp_ARREADY_o = grant ? (MST_AMT'(1) << grant_idx) : '0;

  // R beats follow the oldest outstanding grant; nothing is routed when empty.
  always_comb begin
    dsp_RVALID_o = '0;
    s_RREADY_o   = 1'b0;
    if (!fifo_empty) begin
      dsp_RVALID_o[head] = s_RVALID_i;
      s_RREADY_o         = dsp_RREADY_i[head];
    end
  end

  assign pop         = s_RVALID_i & s_RREADY_o & s_RLAST_i;
  assign dsp_RID_o   = {MST_AMT{s_RID_i}};
  assign dsp_RDATA_o = {MST_AMT{s_RDATA_i}};
  assign dsp_RRESP_o = {MST_AMT{s_RRESP_i}};
  assign dsp_RLAST_o = {MST_AMT{s_RLAST_i}};

  // AR output stage and arbitration pointer.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      rr_ptr      <= '0;
      s_ARVALID_o <= 1'b0;
      s_ARID_o    <= '0;
      s_ARADDR_o  <= '0;
      s_ARBURST_o <= '0;
      s_ARLEN_o   <= '0;
      s_ARSIZE_o  <= '0;
    end else if (grant) begin
      rr_ptr      <= (grant_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_idx + MST_ID_W'(1);
      s_ARVALID_o <= 1'b1;
      s_ARID_o    <= sel_id;
      s_ARADDR_o  <= sel_addr;
      s_ARBURST_o <= sel_burst;
      s_ARLEN_o   <= sel_len;
      s_ARSIZE_o  <= sel_size;
    end else if (s_ARREADY_i) begin
      s_ARVALID_o <= 1'b0;
    end
  end

  // Ordering FIFO control.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (grant) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({grant, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Entry storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge ACLK_i) begin
    if (grant) fifo_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_sa_read_channel.sv
// Directed bench for sa_read_channel: vector table for arbitration and FIFO fill,
// hand-written sequences for R routing, full/pop, backpressure and mid-burst reset.
module tb_sa_read_channel;

  logic        clk;
  logic        rst_n;
  logic [9:0]  ar_id;
  logic [63:0] ar_addr;
  logic [3:0]  ar_burst;
  logic [5:0]  ar_len;
  logic [5:0]  ar_size;
  logic [1:0]  ar_valid;
  logic [1:0]  outst_full;
  logic [1:0]  ar_ready;
  logic [1:0]  r_ready;
  logic [9:0]  r_id;
  logic [63:0] r_data;
  logic [3:0]  r_resp;
  logic [1:0]  r_last;
  logic [1:0]  r_valid;
  logic [4:0]  s_ar_id;
  logic [31:0] s_ar_addr;
  logic [1:0]  s_ar_burst;
  logic [2:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [4:0]  s_r_id;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic        s_r_valid;
  logic        s_r_ready;

  int passed = 0;
  int total  = 0;

  sa_read_channel dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .dsp_ARID_i(ar_id), .dsp_ARADDR_i(ar_addr), .dsp_ARBURST_i(ar_burst),
    .dsp_ARLEN_i(ar_len), .dsp_ARSIZE_i(ar_size), .dsp_ARVALID_i(ar_valid),
    .dsp_AR_outst_full_i(outst_full), .dsp_ARREADY_o(ar_ready),
    .dsp_RREADY_i(r_ready), .dsp_RID_o(r_id), .dsp_RDATA_o(r_data),
    .dsp_RRESP_o(r_resp), .dsp_RLAST_o(r_last), .dsp_RVALID_o(r_valid),
    .s_ARID_o(s_ar_id), .s_ARADDR_o(s_ar_addr), .s_ARBURST_o(s_ar_burst),
    .s_ARLEN_o(s_ar_len), .s_ARSIZE_o(s_ar_size), .s_ARVALID_o(s_ar_valid),
    .s_ARREADY_i(s_ar_ready), .s_RID_i(s_r_id), .s_RDATA_i(s_r_data),
    .s_RRESP_i(s_r_resp), .s_RLAST_i(s_r_last), .s_RVALID_i(s_r_valid),
    .s_RREADY_o(s_r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  arvalid;
    logic [1:0]  full;
    logic        sready;
    logic [1:0]  exp_arready;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ar_valid   = 2'b00;
    outst_full = 2'b00;
    s_ar_ready = 1'b0;
    r_ready    = 2'b00;
    s_r_valid  = 1'b0;
    s_r_last   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic r_beat(input logic last, input logic [1:0] exp_rv, input string name);
    s_r_valid = 1'b1;
    s_r_last  = last;
    r_ready   = 2'b11;
    #1;
    check({name, "_rvalid"}, 64'(r_valid), 64'(exp_rv));
    check({name, "_srready"}, 64'(s_r_ready), 64'd1);
    tick();
    s_r_valid = 1'b0;
    s_r_last  = 1'b0;
  endtask

  initial begin
    ar_id    = {5'd7, 5'd3};
    ar_addr  = {32'h80, 32'h40};
    ar_burst = {2'd1, 2'd1};
    ar_len   = {3'd0, 3'd2};
    ar_size  = {3'd2, 3'd2};
    s_r_id   = 5'd3;
    s_r_data = 32'hCAFE_0001;
    s_r_resp = 2'd0;
    clear_inputs();

    //            arvalid full  rdy exp_rdy vld addr
    vecs[0]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 32'h40};
    vecs[1]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 32'h80};
    vecs[2]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 32'h40};
    vecs[3]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 32'h80};
    vecs[4]  = '{2'b11, 2'b01, 1'b1, 2'b10, 1'b1, 32'h80};
    vecs[5]  = '{2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 32'h40};
    vecs[6]  = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 32'h40};
    vecs[7]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 32'h40};
    vecs[8]  = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 32'h40};
    vecs[9]  = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 32'h80};
    vecs[10] = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 32'h80};

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_s_arvalid", 64'(s_ar_valid), 64'd0);
    check("rst_s_araddr", 64'(s_ar_addr), 64'd0);
    check("rst_arready", 64'(ar_ready), 64'd0);
    check("rst_rvalid", 64'(r_valid), 64'd0);
    check("rst_srready", 64'(s_r_ready), 64'd0);
    check("rst_count", 64'(dut.fifo_count), 64'd0);
    do_reset();

    // Single request
    ar_valid   = 2'b01;
    s_ar_ready = 1'b1;
    #1;
    check("single_arready", 64'(ar_ready), 64'b01);
    tick();
    ar_valid = 2'b00;
    check("single_s_arvalid", 64'(s_ar_valid), 64'd1);
    check("single_s_araddr", 64'(s_ar_addr), 64'h40);
    check("single_s_arid", 64'(s_ar_id), 64'd3);
    check("single_s_arlen", 64'(s_ar_len), 64'd2);
    check("single_count", 64'(dut.fifo_count), 64'd1);
    tick();
    check("single_s_arvalid_clr", 64'(s_ar_valid), 64'd0);

    // Arbitration and FIFO fill table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      ar_valid   = vecs[i].arvalid;
      outst_full = vecs[i].full;
      s_ar_ready = vecs[i].sready;
      #1;
      check($sformatf("vec%0d_arready", i), 64'(ar_ready), 64'(vecs[i].exp_arready));
      tick();
      check($sformatf("vec%0d_s_arvalid", i), 64'(s_ar_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_s_araddr", i), 64'(s_ar_addr), 64'(vecs[i].exp_addr));
    end
    check("table_count_full", 64'(dut.fifo_count), 64'd8);

    // Full FIFO: a pop does not allow a grant in the same cycle
    ar_valid   = 2'b01;
    outst_full = 2'b00;
    s_ar_ready = 1'b1;
    #1;
    check("full_arready", 64'(ar_ready), 64'b00);
    s_r_valid = 1'b1;
    s_r_last  = 1'b1;
    r_ready   = 2'b11;
    #1;
    check("full_pop_rvalid", 64'(r_valid), 64'b01);
    check("full_pop_arready", 64'(ar_ready), 64'b00);
    tick();
    s_r_valid = 1'b0;
    s_r_last  = 1'b0;
    check("full_after_pop_count", 64'(dut.fifo_count), 64'd7);
    #1;
    check("full_resume_arready", 64'(ar_ready), 64'b01);
    tick();
    ar_valid = 2'b00;
    check("full_refill_count", 64'(dut.fifo_count), 64'd8);

    // R routing: FIFO holds {1,0}
    do_reset();
    s_ar_ready = 1'b1;
    ar_valid   = 2'b10;
    tick();
    ar_valid = 2'b01;
    tick();
    ar_valid = 2'b00;
    check("route_count", 64'(dut.fifo_count), 64'd2);
    s_r_valid = 1'b1;
    r_ready   = 2'b01;
    #1;
    check("route_gate_srready", 64'(s_r_ready), 64'd0);
    check("route_gate_rvalid", 64'(r_valid), 64'b10);
    check("route_rdata_repl", r_data, {2{32'hCAFE_0001}});
    r_beat(1'b0, 2'b10, "beat1");
    check("beat1_count", 64'(dut.fifo_count), 64'd2);
    r_beat(1'b0, 2'b10, "beat2");
    check("beat2_count", 64'(dut.fifo_count), 64'd2);
    r_beat(1'b1, 2'b10, "beat3");
    check("beat3_count", 64'(dut.fifo_count), 64'd1);
    r_beat(1'b1, 2'b01, "beat4");
    check("beat4_count", 64'(dut.fifo_count), 64'd0);
    s_r_valid = 1'b1;
    #1;
    check("empty_rvalid", 64'(r_valid), 64'b00);
    check("empty_srready", 64'(s_r_ready), 64'd0);
    s_r_valid = 1'b0;

    // AR backpressure
    do_reset();
    ar_valid   = 2'b01;
    s_ar_ready = 1'b0;
    #1;
    check("bp_first_arready", 64'(ar_ready), 64'b01);
    tick();
    ar_addr  = {32'h80, 32'h44};
    ar_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_arready", c), 64'(ar_ready), 64'b00);
      check($sformatf("bp%0d_s_araddr", c), 64'(s_ar_addr), 64'h40);
      check($sformatf("bp%0d_s_arvalid", c), 64'(s_ar_valid), 64'd1);
      tick();
    end
    s_ar_ready = 1'b1;
    #1;
    check("bp_release_arready", 64'(ar_ready), 64'b10);
    tick();
    ar_valid = 2'b00;
    check("bp_release_s_araddr", 64'(s_ar_addr), 64'h80);
    tick();
    check("bp_release_s_arvalid", 64'(s_ar_valid), 64'd0);
    ar_addr = {32'h80, 32'h40};

    // Mid-burst reset with a pending AR
    do_reset();
    s_ar_ready = 1'b1;
    ar_valid   = 2'b11;
    repeat (3) tick();
    ar_valid   = 2'b00;
    s_ar_ready = 1'b0;
    check("mid_count_pre", 64'(dut.fifo_count), 64'd3);
    check("mid_ptr_pre", 64'(dut.rr_ptr), 64'd1);
    s_r_valid = 1'b1;
    s_r_last  = 1'b0;
    r_ready   = 2'b11;
    #1;
    check("mid_rvalid_pre", 64'(r_valid), 64'b01);
    rst_n = 1'b0;
    #1;
    check("mid_rvalid", 64'(r_valid), 64'b00);
    check("mid_srready", 64'(s_r_ready), 64'd0);
    check("mid_s_arvalid", 64'(s_ar_valid), 64'd0);
    check("mid_s_araddr", 64'(s_ar_addr), 64'd0);
    check("mid_arready", 64'(ar_ready), 64'b00);
    check("mid_count", 64'(dut.fifo_count), 64'd0);
    check("mid_ptr", 64'(dut.rr_ptr), 64'd0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sa_read_channel.md
SA_READ_CHANNEL -- requirements
Module: sa_read_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 2, meaning the number of dispatchers (masters) competing for this slave.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8, meaning the maximum number of accepted AR transactions whose R burst is not yet complete.
REQ-003 SHALL have parameters DATA_WIDTH 32, ADDR_WIDTH 32, TRANS_MST_ID_W 5, TRANS_BURST_W 2, TRANS_DATA_LEN_W 3, TRANS_DATA_SIZE_W 3 and TRANS_WR_RESP_W 2, each meaning the AXI field width of the same name.
REQ-004 SHALL have derived parameter MST_ID_W = $clog2(MST_AMT), the width of a master index.
REQ-005 SHALL have the ports listed below, in this order.
- ACLK_i  in  1  the one clock
- ARESETn_i  in  1  asynchronous active-low reset
- dsp_ARID_i / dsp_ARADDR_i / dsp_ARBURST_i / dsp_ARLEN_i / dsp_ARSIZE_i  in  field_W*MST_AMT  per-dispatcher AR fields; slice i belongs to dispatcher i
- dsp_ARVALID_i  in  MST_AMT  per-dispatcher AR valid
- dsp_AR_outst_full_i  in  MST_AMT  dispatcher i is at its outstanding limit
- dsp_ARREADY_o  out  MST_AMT  one-hot AR accept
- dsp_RREADY_i  in  MST_AMT  per-dispatcher R ready
- dsp_RID_o / dsp_RDATA_o / dsp_RRESP_o / dsp_RLAST_o  out  field_W*MST_AMT  R fields, the same value replicated to every slice
- dsp_RVALID_o  out  MST_AMT  one-hot R valid
- s_ARID_o / s_ARADDR_o / s_ARBURST_o / s_ARLEN_o / s_ARSIZE_o  out  field_W  AR fields to the slave
- s_ARVALID_o  out  1  AR valid to the slave
- s_ARREADY_i  in  1  AR ready from the slave
- s_RID_i / s_RDATA_i / s_RRESP_i / s_RLAST_i / s_RVALID_i  in  field_W  R fields from the slave
- s_RREADY_o  out  1  R ready to the slave

Function
REQ-006 Request i SHALL be eligible when dsp_ARVALID_i[i]=1 and dsp_AR_outst_full_i[i]=0.
REQ-007 Arbitration SHALL be round-robin: the search starts at pointer P and takes the first eligible index going upward modulo MST_AMT; P resets to 0.
REQ-008 After a grant to index g, P SHALL become (g+1) mod MST_AMT; P SHALL hold when no grant occurs.
REQ-009 A grant SHALL occur only when at least one request is eligible, the AR output stage is free, and the ordering FIFO is not full.
- The AR output stage is free when s_ARVALID_o=0, or when s_ARVALID_o=1 and s_ARREADY_i=1.
REQ-010 dsp_ARREADY_o SHALL be combinational and one-hot at bit g in the grant cycle, and zero otherwise.
REQ-011 On a grant, the granted slice's AR fields SHALL be registered into the s_AR* outputs and s_ARVALID_o SHALL be set, giving one cycle latency.
REQ-012 s_ARVALID_o SHALL clear after a slave handshake that has no simultaneous new grant.
REQ-013 s_AR* fields SHALL stay stable while s_ARVALID_o=1 and s_ARREADY_i=0.
REQ-014 Each grant SHALL push g into the ordering FIFO, which has depth OUTSTANDING_AMT and width MST_ID_W.
REQ-015 The occupancy count of the ordering FIFO SHALL be $clog2(OUTSTANDING_AMT)+1 bits wide.
REQ-016 The read and write pointers of the ordering FIFO SHALL wrap modulo OUTSTANDING_AMT.
REQ-017 R routing SHALL be combinational. With the FIFO head h and the FIFO not empty:
- dsp_RVALID_o[h] = s_RVALID_i, all other bits 0
- s_RREADY_o = dsp_RREADY_i[h]
REQ-018 When the FIFO is empty, dsp_RVALID_o SHALL be 0 and s_RREADY_o SHALL be 0.
REQ-019 The FIFO SHALL pop on a handshake with s_RVALID_i=1, s_RREADY_o=1 and s_RLAST_i=1; beats with RLAST=0 SHALL NOT pop.
REQ-020 A simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-021 When the FIFO is full, no grant SHALL occur, even if a pop happens in the same cycle; the grant resumes on the next cycle.
REQ-022 The slave SHALL return R bursts in AR acceptance order; this block SHALL NOT reorder bursts.

Reset
REQ-023 While ARESETn_i=0, the block SHALL force the following asynchronously:
- s_ARVALID_o=0 and s_AR* fields all 0
- FIFO pointers and count 0
- P=0
REQ-024 After reset, dsp_ARREADY_o, dsp_RVALID_o and s_RREADY_o SHALL evaluate to 0 because the FIFO is empty and no request is pending.
REQ-025 Reset asserted mid-burst SHALL discard all outstanding ordering entries and any pending AR without completing them.

Verification
REQ-026 Bench SHALL cover single request: dsp_ARVALID_i=2'b01, ARADDR slice0=0x40, s_ARREADY_i=1 -> dsp_ARREADY_o=2'b01 in cycle N, s_ARVALID_o=1 with s_ARADDR_o=0x40 in cycle N+1, count=1.
REQ-027 Bench SHALL cover round-robin: dsp_ARVALID_i=2'b11 held for 4 grants -> grant order 0,1,0,1.
REQ-028 Bench SHALL cover R routing: FIFO holds {1,0}, slave returns a 3-beat burst then a 1-beat burst -> the 3 beats go to dsp_RVALID_o=2'b10 and the single beat to 2'b01; the count drops by 1 only on each RLAST.
REQ-029 Bench SHALL cover FIFO full: 8 grants with no R -> dsp_ARREADY_o=0. In the cycle of the RLAST pop, no grant occurs; the grant follows on the next cycle.
REQ-030 Bench SHALL cover backpressure: s_ARREADY_i=0 for 5 cycles -> s_AR* stable, dsp_ARREADY_o=0, then one transfer on release.
REQ-031 Bench SHALL cover mid-burst reset: ARESETn_i=0 during a beat with RLAST=0 -> all outputs 0 immediately, count=0, P=0.
